// File: rtl/mul_add_pkg.sv
// Shared definitions for the shift-and-add multiply-accumulate block and its divider peers.
// State encodings are common across the family so paired blocks can be compared directly.
package mul_add_pkg;

  typedef enum logic [1:0] {
    ST_READY     = 2'd0,
    ST_INITS     = 2'd1,
    ST_WAITING   = 2'd2,
    ST_RESTARTED = 2'd3
  } state_t;

  // Width of a counter that must hold the values 0..b_w inclusive.
  function automatic int cnt_width(input int b_w);
    return $clog2(b_w + 1);
  endfunction

endpackage

// File: rtl/mul_add_by_shift.sv
// Sequential result = multiplicand * multiplier + addend, one multiplier bit per iteration.
// Define MUL_ADD_FAST_LOOP_EN for one cycle per iteration; the default takes two, in step with the divider.
module mul_add_by_shift
  import mul_add_pkg::*;
#(
  parameter int A_W = 8,
  parameter int B_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [A_W-1:0]     multiplicand,
  input  logic [B_W-1:0]     multiplier,
  input  logic [A_W-1:0]     addend,
  output logic [A_W+B_W-1:0] result,
  output logic               result_ready
);

  localparam int R_W   = A_W + B_W;
  localparam int CNT_W = cnt_width(B_W);

  state_t           state_reg;
  logic [R_W-1:0]   acc_reg;
  logic [R_W-1:0]   a_sh_reg;
  logic [R_W-1:0]   b_sh_reg;
  logic [CNT_W-1:0] i_reg;

  // Combinational on start so a requester sees busy in the same cycle it asks.
  assign result_ready = (state_reg == ST_READY) && !start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_READY;
      result    <= '0;
      acc_reg   <= '0;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      i_reg     <= '0;
    end else if (start) begin
      // A new request abandons any operation in flight; its result is never written.
      state_reg <= ST_INITS;
    end else begin
      case (state_reg)
        ST_READY: begin
          state_reg <= ST_READY;
        end
        ST_INITS: begin
          acc_reg   <= {{B_W{1'b0}}, addend};
          a_sh_reg  <= {{B_W{1'b0}}, multiplicand};
          b_sh_reg  <= {{A_W{1'b0}}, multiplier};
          i_reg     <= CNT_W'(B_W);
          state_reg <= ST_RESTARTED;
        end
        ST_RESTARTED: begin
          state_reg <= ST_WAITING;
        end
        ST_WAITING: begin
          // Stop as soon as no multiplier bits remain, so latency tracks bit-length.
          if (i_reg == '0 || b_sh_reg == '0) begin
            result    <= acc_reg;
            state_reg <= ST_READY;
          end else begin
            if (b_sh_reg[0]) begin
              acc_reg <= acc_reg + a_sh_reg;
            end
            a_sh_reg <= a_sh_reg << 1;
            b_sh_reg <= b_sh_reg >> 1;
            i_reg    <= i_reg - CNT_W'(1);
`ifdef MUL_ADD_FAST_LOOP_EN
            state_reg <= ST_WAITING;
`else
            state_reg <= ST_RESTARTED;
`endif
          end
        end
        default: begin
          state_reg <= ST_READY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_add_by_shift.sv
// Bench for mul_add_by_shift: directed, random and divider round-trip operations against a timing/value model.
// Honours MUL_ADD_FAST_LOOP_EN for the expected iteration cost.
module tb_mul_add_by_shift;

  localparam int A_W = 8;
  localparam int B_W = 4;
  localparam int R_W = A_W + B_W;
`ifdef MUL_ADD_FAST_LOOP_EN
  localparam int K = 1;
`else
  localparam int K = 2;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [A_W-1:0] a = '0;
  logic [B_W-1:0] b = '0;
  logic [A_W-1:0] c = '0;
  logic [R_W-1:0] result;
  logic           result_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_add_by_shift #(.A_W(A_W), .B_W(B_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (a),
    .multiplier   (b),
    .addend       (c),
    .result       (result),
    .result_ready (result_ready)
  );

  function automatic int bitlen(input int v);
    int n = 0;
    while (v != 0) begin
      n++;
      v = v >> 1;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: an operation started at edge s captures operands at s+1 and publishes a*b+c
  // at edge s+3+K*bitlen(b), unless another start or a reset intervenes.
  int e = 0;
  int m_start_e = 0;
  int m_done = 0;
  int m_exp = 0;
  int m_result = 0;
  bit m_pend = 0;
  bit m_cap = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend   <= 1'b0;
      m_cap    <= 1'b0;
      m_result <= 0;
    end else begin
      e <= e + 1;
      if (start) begin
        m_pend    <= 1'b1;
        m_cap     <= 1'b0;
        m_start_e <= e;
      end else if (m_pend && !m_cap) begin
        m_cap  <= 1'b1;
        m_exp  <= int'(a) * int'(b) + int'(c);
        m_done <= m_start_e + 3 + K * bitlen(int'(b));
      end else if (m_pend && m_cap && e == m_done) begin
        m_result <= m_exp;
        m_pend   <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("cycle_ready", {31'd0, result_ready}, {31'd0, (!m_pend && !start)});
      chk("cycle_result", {20'd0, result}, m_result);
    end
  end

  task automatic run_op(input string name, input int av, input int bv, input int cv,
                        input int hold, input int exp_val, input int exp_lat);
    int cnt;
    @(posedge clk);
    #2;
    a = A_W'(av);
    b = B_W'(bv);
    c = A_W'(cv);
    start = 1'b1;
    repeat (hold) @(posedge clk);
    #2 start = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!result_ready && cnt < 40);
    chk({name, "_latency"}, cnt - 1, exp_lat);
    chk({name, "_value"}, {20'd0, result}, exp_val);
    $display("op %s a=%0d b=%0d c=%0d hold=%0d -> result=%0d after E%0d", name, av, bv, cv, hold, result, cnt - 1);
  endtask

  initial begin
    int av, bv, cv, hold, q, r, cnt;
    bit saw_old;

    #1 reset = 1'b1;
    #1;
    chk("reset_result", {20'd0, result}, 0);
    chk("reset_ready", {31'd0, result_ready}, 1);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    run_op("t13x5p2", 13, 5, 2, 1, 67, 3 + K * 3);
    run_op("t200x0", 200, 0, 'hAB, 1, 'hAB, 3);
    run_op("tfull", 255, 15, 255, 1, 4080, 3 + K * 4);
    run_op("tzero_a", 0, 9, 77, 1, 77, 3 + K * 4);
    run_op("thold3", 6, 3, 1, 3, 19, 3 + K * 2);

    // Restart mid-operation: the abandoned 255*15 must never surface.
    @(posedge clk);
    #2;
    a = 8'd255; b = 4'd15; c = 8'd0; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    a = 8'd3; b = 4'd2; c = 8'd1; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    cnt = 0;
    saw_old = 1'b0;
    do begin
      @(negedge clk);
      cnt++;
      if (result == 12'd3825) saw_old = 1'b1;
    end while (!result_ready && cnt < 40);
    repeat (12) begin
      @(negedge clk);
      if (result == 12'd3825) saw_old = 1'b1;
    end
    chk("restart_latency", cnt - 1, 3 + K * 2);
    chk("restart_value", {20'd0, result}, 7);
    chk("restart_no_3825", {31'd0, saw_old}, 0);
    $display("op restart a=3 b=2 c=1 -> result=%0d after E%0d", result, cnt - 1);

    // Asynchronous reset while iterating.
    @(posedge clk);
    #2;
    a = 8'd255; b = 4'd15; c = 8'd0; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midreset_result", {20'd0, result}, 0);
    chk("midreset_ready", {31'd0, result_ready}, 1);
    $display("op midreset -> result=%0d ready=%0d", result, result_ready);
    #1 reset = 1'b0;
    run_op("post_reset", 13, 5, 2, 1, 67, 3 + K * 3);

    for (int n = 0; n < 300; n++) begin
      av = $urandom_range(0, 255);
      bv = $urandom_range(0, 15);
      cv = $urandom_range(0, 255);
      hold = $urandom_range(1, 3);
      run_op("rand", av, bv, cv, hold, av * bv + cv, 3 + K * bitlen(bv));
    end

    for (int dividend = 0; dividend < 256; dividend++) begin
      for (int divisor = 1; divisor < 16; divisor++) begin
        q = dividend / divisor;
        r = dividend % divisor;
        run_op("roundtrip", q, divisor, r, 1, dividend, 3 + K * bitlen(divisor));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
